// File: rtl/ham_result_checker.sv
// Post-halt checker: reloads the operand bytes, finds the max pairwise Hamming distance, compares with the program's answer.
// Optional run-cycle counter on cycle_ct is built only when HAM_CYCLE_COUNT_EN is defined.
module ham_result_checker #(
    parameter int BASE        = 128,
    parameter int COUNT       = 20,
    parameter int RESULT_ADDR = 127,
    parameter int AW          = 8
) (
    input  logic          CLK,
    input  logic          Reset_n,
    input  logic          start,
    input  logic          Halt,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [3:0]    ham_max,
    output logic [AW-1:0] idx_i,
    output logic [AW-1:0] idx_j,
    output logic [7:0]    dut_result,
    output logic [31:0]   cycle_ct
);

    localparam int IW = (COUNT > 2) ? $clog2(COUNT) : 1;
    localparam int KW = $clog2(COUNT + 1);

    if (COUNT < 2 || COUNT > 32) begin : g_bad_count
        $error("ham_result_checker: COUNT must be in 2..32");
    end
    if (BASE + COUNT > 2 ** AW) begin : g_bad_range
        $error("ham_result_checker: operand range exceeds address space");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SCAN, S_RDRES, S_CMP, S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_halt;
    logic            r_rd_en;
    logic [AW-1:0]   r_addr;
    logic            r_vld;
    logic [KW-1:0]   r_k;
    logic [IW-1:0]   r_wp;
    logic [IW-1:0]   r_i;
    logic [IW-1:0]   r_j;
    logic [7:0]      r_buf [COUNT];
    logic [3:0]      r_max;
    logic [AW-1:0]   r_idx_i;
    logic [AW-1:0]   r_idx_j;
    logic [7:0]      r_res;
    logic            r_pass;
    logic            w_launch;
    logic            w_load_last;
    logic            w_scan_last;
    logic            w_row_end;
    logic [3:0]      w_d;

    function automatic logic [3:0] f_popcnt(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int b = 0; b < 8; b++) begin
            c = c + {3'b000, v[b]};
        end
        return c;
    endfunction

    // Launch only on a fresh Halt edge, and only while not mid-check.
    assign w_launch    = Halt & ~r_halt &
                         ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_load_last = r_vld && (r_wp == IW'(COUNT - 1));
    assign w_row_end   = (r_j == IW'(COUNT - 1));
    assign w_scan_last = w_row_end && (r_i == IW'(COUNT - 2));
    assign w_d         = f_popcnt(r_buf[r_i] ^ r_buf[r_j]);

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_launch) w_next = S_LOAD;
            S_LOAD:  if (w_load_last) w_next = S_SCAN;
            S_SCAN:  if (w_scan_last) w_next = S_RDRES;
            S_RDRES: w_next = S_CMP;
            S_CMP:   w_next = S_DONE;
            S_DONE:  if (w_launch) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_halt  <= 1'b0;
            r_rd_en <= 1'b0;
            r_addr  <= '0;
            r_vld   <= 1'b0;
            r_k     <= '0;
            r_wp    <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_max   <= 4'd0;
            r_idx_i <= '0;
            r_idx_j <= '0;
            r_res   <= 8'd0;
            r_pass  <= 1'b0;
            for (int n = 0; n < COUNT; n++) begin
                r_buf[n] <= 8'd0;
            end
        end else begin
            r_halt <= Halt;
            r_vld  <= r_rd_en;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_launch) begin
                        r_rd_en <= 1'b1;
                        r_addr  <= AW'(BASE);
                        r_k     <= KW'(1);
                        r_wp    <= '0;
                        r_pass  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (r_k < KW'(COUNT)) begin
                        r_addr <= AW'(BASE) + AW'(r_k);
                        r_k    <= r_k + KW'(1);
                    end else begin
                        r_rd_en <= 1'b0;
                    end
                    // Read data trails the strobe by one cycle.
                    if (r_vld) begin
                        r_buf[r_wp] <= mem_rdata;
                        r_wp        <= r_wp + IW'(1);
                    end
                    if (w_load_last) begin
                        r_max   <= 4'd0;
                        r_idx_i <= AW'(BASE);
                        r_idx_j <= AW'(BASE + 1);
                        r_i     <= '0;
                        r_j     <= IW'(1);
                    end
                end
                S_SCAN: begin
                    // Strict compare keeps the earliest pair on ties.
                    if (w_d > r_max) begin
                        r_max   <= w_d;
                        r_idx_i <= AW'(BASE) + AW'(r_i);
                        r_idx_j <= AW'(BASE) + AW'(r_j);
                    end
                    if (w_scan_last) begin
                        r_rd_en <= 1'b1;
                        r_addr  <= AW'(RESULT_ADDR);
                    end else if (w_row_end) begin
                        r_i <= r_i + IW'(1);
                        r_j <= r_i + IW'(2);
                    end else begin
                        r_j <= r_j + IW'(1);
                    end
                end
                S_RDRES: begin
                    r_rd_en <= 1'b0;
                end
                S_CMP: begin
                    r_res  <= mem_rdata;
                    r_pass <= (mem_rdata == {4'b0000, r_max});
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_rd_en  = r_rd_en;
    assign mem_addr   = r_addr;
    assign busy       = (r_state == S_LOAD) || (r_state == S_SCAN) ||
                        (r_state == S_RDRES) || (r_state == S_CMP);
    assign done       = (r_state == S_DONE);
    assign pass       = r_pass;
    assign ham_max    = r_max;
    assign idx_i      = r_idx_i;
    assign idx_j      = r_idx_j;
    assign dut_result = r_res;

`ifdef HAM_CYCLE_COUNT_EN
    logic [31:0] r_cyc;

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_cyc <= 32'd0;
        end else if (start) begin
            r_cyc <= 32'd0;
        end else if (!Halt) begin
            r_cyc <= r_cyc + 32'd1;
        end
    end

    assign cycle_ct = r_cyc;
`else
    logic w_unused;

    assign w_unused = start;
    assign cycle_ct = 32'd0;
`endif

endmodule

// File: tb/tb_ham_result_checker.sv
// Scoreboard bench for ham_result_checker: driver queues expected results, monitor checks on each done rise.
// Expected cycle_ct follows HAM_CYCLE_COUNT_EN.
module tb_ham_result_checker;

`ifdef HAM_CYCLE_COUNT_EN
    localparam int EXP_CYC = 37;
`else
    localparam int EXP_CYC = 0;
`endif
    localparam int EXP_LAT = 214;

    typedef struct {
        logic [3:0]  ham;
        logic [7:0]  ii;
        logic [7:0]  jj;
        logic [7:0]  res;
        logic        p;
        logic [31:0] cyc;
        int          hc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halt;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata = 8'd0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  ham_max;
    logic [7:0]  idx_i;
    logic [7:0]  idx_j;
    logic [7:0]  dut_result;
    logic [31:0] cycle_ct;

    logic [7:0]  mem [256];
    exp_t        q [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          done_q = 1'b0;

    ham_result_checker dut (
        .CLK        (clk),
        .Reset_n    (rst_n),
        .start      (start),
        .Halt       (halt),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .ham_max    (ham_max),
        .idx_i      (idx_i),
        .idx_j      (idx_j),
        .dut_result (dut_result),
        .cycle_ct   (cycle_ct)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare every completed check against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done === 1'b1 && !done_q) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("latency", cyc - e.hc, EXP_LAT);
                chk("ham_max", ham_max, e.ham);
                chk("idx_i", idx_i, e.ii);
                chk("idx_j", idx_j, e.jj);
                chk("dut_result", dut_result, e.res);
                chk("pass", pass, e.p);
                chk("busy_done", busy, 0);
                chk("cycle_ct", cycle_ct, e.cyc);
            end
        end
        done_q = (done === 1'b1);
    end

    task automatic fill(input int scen, input logic [7:0] res);
        for (int a = 128; a < 148; a++) begin
            mem[a] = (scen == 1) ? 8'hFF : 8'h00;
        end
        if (scen == 0) begin
            mem[135] = 8'h12;
            mem[140] = 8'hED;
        end else if (scen == 1) begin
            mem[128] = 8'hFF;
            mem[129] = 8'h00;
            mem[130] = 8'h00;
        end
        mem[127] = res;
    endtask

    task automatic prime();
        halt  = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        repeat (37) @(posedge clk);
        #1 halt = 1'b1;
    endtask

    task automatic run(input logic [3:0] h, input logic [7:0] ii,
                       input logic [7:0] jj, input logic [7:0] res,
                       input logic p);
        exp_t e;
        int   t;
        prime();
        e.ham = h;
        e.ii  = ii;
        e.jj  = jj;
        e.res = res;
        e.p   = p;
        e.cyc = EXP_CYC;
        e.hc  = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        t = 0;
        while (done !== 1'b1 && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("done_seen", done, 1);
        repeat (3) @(posedge clk);
        #1 chk("hold_done", {done, busy, mem_rd_en}, 3'b100);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        rst_n = 1'b0;
        start = 1'b1;
        halt  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {mem_rd_en, mem_addr, busy, done, pass, ham_max,
             idx_i, idx_j, dut_result, cycle_ct}, 0);
        rst_n = 1'b1;

        fill(0, 8'd8);
        run(4'd8, 8'd135, 8'd140, 8'd8, 1'b1);
        fill(1, 8'd8);
        run(4'd8, 8'd128, 8'd129, 8'd8, 1'b1);
        fill(0, 8'd7);
        run(4'd8, 8'd135, 8'd140, 8'd7, 1'b0);
        fill(0, 8'h18);
        run(4'd8, 8'd135, 8'd140, 8'h18, 1'b0);
        fill(2, 8'd0);
        run(4'd0, 8'd128, 8'd129, 8'd0, 1'b1);

        fill(0, 8'd8);
        prime();
        repeat (50) @(posedge clk);
        #1 chk("busy_midscan", busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_reset",
            {mem_rd_en, mem_addr, busy, done, pass, ham_max,
             idx_i, idx_j, dut_result, cycle_ct}, 0);
        halt = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        run(4'd8, 8'd135, 8'd140, 8'd8, 1'b1);

        repeat (5) @(posedge clk);
        #1 chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ham_result_checker.md
Name: ham_result_checker

Overview:
- Hardware checker that sits directly downstream of TopLevel on the data-memory read port. It consumes what the program produces.
- When TopLevel asserts Halt, the block:
  - reads the COUNT operand bytes at BASE..BASE+COUNT-1;
  - computes the maximum pairwise Hamming distance in hardware;
  - reads the program's answer at RESULT_ADDR;
  - flags pass/fail.
- Replaces the bench-side golden loop so regressions can run in hardware/emulation.

Parameters:
- BASE, 128, first operand address
- COUNT, 20, number of operand bytes; must satisfy 2 ≤ COUNT ≤ 32
- RESULT_ADDR, 127, address where the program writes its maximum distance
- AW, 8, memory address width; elaboration error if BASE+COUNT > 2**AW

Ports:
- CLK  input  1  system clock
- Reset_n  input  1  synchronous active-low reset
- start  input  1  TopLevel start/init (high = init, low = run); used only by the cycle counter
- Halt  input  1  TopLevel done flag
- mem_rd_en  output  1  read strobe to data memory
- mem_addr  output  AW  read address
- mem_rdata  input  8  read data, valid exactly 1 cycle after mem_rd_en
- busy  output  1  check in progress
- done  output  1  check complete, result outputs valid
- pass  output  1  DUT answer equals computed maximum
- ham_max  output  4  computed maximum distance (0..8)
- idx_i  output  AW  address of first byte of the max pair
- idx_j  output  AW  address of second byte of the max pair
- dut_result  output  8  byte read from RESULT_ADDR
- cycle_ct  output  32  TopLevel run-cycle count (see Optional Feature)

Behaviour:
- Reset (Reset_n=0 at a CLK edge): state=IDLE; every output is 0; internal operand buffer and counters are cleared.
  - Reset wins over all other events, including mid-run; any in-flight check is abandoned with no partial done.
- Halt is registered internally; a run launches on the Halt 0→1 edge seen in IDLE or DONE.
  - Halt held high does not relaunch.
  - Halt falling mid-run is ignored; the run completes.
- FSM states: IDLE → LOAD → SCAN → RDRES → CMP → DONE.
- LOAD: issue mem_rd_en with mem_addr=BASE+k for k=0..COUNT-1 on consecutive cycles. Capture mem_rdata into buf[k] one cycle later. Leave after the last capture; duration COUNT+1 cycles.
- SCAN:
  - At entry, set ham_max=0, idx_i=BASE, idx_j=BASE+1.
  - Evaluate one pair per cycle, i=0..COUNT-2 outer, j=i+1..COUNT-1 inner: d = popcount(buf[i] ^ buf[j]), 4-bit.
  - Update only when d > ham_max (strict), so the first (i,j) in scan order is kept on ties. idx_i=BASE+i, idx_j=BASE+j.
  - Duration COUNT*(COUNT-1)/2 cycles (190 for COUNT=20).
  - All-equal operands leave ham_max=0 and indices BASE/BASE+1.
- RDRES: one cycle with mem_rd_en=1, mem_addr=RESULT_ADDR.
- CMP: capture dut_result=mem_rdata; pass=(mem_rdata == {4'b0,ham_max}). Any nonzero upper nibble fails.
- DONE: done=1, busy=0. All result outputs hold until reset or the next Halt rising edge, which clears done/pass and re-enters LOAD.
- busy=1 in LOAD..CMP. mem_rd_en=0 outside LOAD and RDRES; mem_addr holds its last value.
- Latency from Halt edge to done: COUNT+1 + COUNT(COUNT-1)/2 + 2 + 1 cycles (214 for COUNT=20).

Optional Feature:
- Macro HAM_CYCLE_COUNT_EN.
- Defined: cycle_ct clears while start=1 and increments by 1 on each CLK edge with start=0 and Halt=0. It freezes once Halt=1 and wraps modulo 2**32.
- Not defined: cycle_ct tied to 0 and no counter logic is generated.

Test Plan:
- Single pair max: mem[128..147] all 8'h00 except mem[135]=8'h12, mem[140]=8'hED; mem[127]=8 → ham_max=8, idx_i=135, idx_j=140, pass=1, done at 214 cycles after Halt edge.
- Tie ordering: mem[128]=8'hFF, mem[129]=8'h00, mem[130]=8'h00, rest 8'hFF; mem[127]=8 → idx_i=128, idx_j=129 (first in scan order), pass=1.
- Wrong answer: same as first scenario but mem[127]=7 → pass=0, dut_result=7, ham_max=8; mem[127]=8'h18 → pass=0.
- All zero: all operands 8'h00, mem[127]=0 → ham_max=0, idx 128/129, pass=1.
- Reset mid-SCAN: assert Reset_n=0 at 50 cycles after Halt edge → next cycle all outputs 0, state IDLE; a new Halt edge then completes normally.
- Cycle counter (macro on): start=0 for 37 cycles, then Halt=1 → cycle_ct=37 and holds; macro off → cycle_ct stays 0.
